// File: rtl/dff_err_readout_master.sv
// Link master for the error-count serial readout: pulses save_data, clocks out a
// frame of NUM_WORDS x WORD_W bits on data_clk and deserialises the returned bits.
module dff_err_readout_master #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned NUM_WORDS   = 20,
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned SAVE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              data_in,
  output logic              save_data,
  output logic              data_clk,
  output logic              busy,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [4:0]        word_idx,
  output logic              done,
  output logic [15:0]       frame_count
);

  localparam int unsigned BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned CNT_MAX = (CLK_DIV > SAVE_CYCLES) ? CLK_DIV : SAVE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [4:0]        word_q, word_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              din_meta_q, din_s_q;
  logic              save_data_q, save_data_d;
  logic              data_clk_q, data_clk_d;
  logic              busy_q, busy_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic [4:0]        word_idx_q, word_idx_d;
  logic              done_q, done_d;
  logic [15:0]       frame_count_q, frame_count_d;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    word_d        = word_q;
    sr_d          = sr_q;
    word_valid_d  = 1'b0;
    word_data_d   = word_data_q;
    word_idx_d    = word_idx_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_SAVE;
      end
      S_SAVE: begin
        if (cnt_q == CNT_W'(SAVE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          // Sample at the end of the low phase, just before the slave advances
          sr_d    = {sr_q[WORD_W-2:0], din_s_q};
          cnt_d   = '0;
          state_d = S_HIGH;
          if (bit_q == BIT_W'(WORD_W - 1)) begin
            word_valid_d = 1'b1;
            word_data_d  = sr_d;
            word_idx_d   = word_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = S_LOW;
          if (bit_q == BIT_W'(WORD_W - 1)) begin
            bit_d = '0;
            if (word_q == 5'(NUM_WORDS - 1)) begin
              state_d       = S_DONE;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              word_d = word_q + 5'd1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        word_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    save_data_d = (state_d == S_SAVE);
    data_clk_d  = (state_d == S_HIGH);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      word_q        <= '0;
      sr_q          <= '0;
      din_meta_q    <= 1'b0;
      din_s_q       <= 1'b0;
      save_data_q   <= 1'b0;
      data_clk_q    <= 1'b0;
      busy_q        <= 1'b0;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_idx_q    <= '0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      word_q        <= word_d;
      sr_q          <= sr_d;
      din_meta_q    <= data_in;
      din_s_q       <= din_meta_q;
      save_data_q   <= save_data_d;
      data_clk_q    <= data_clk_d;
      busy_q        <= busy_d;
      word_valid_q  <= word_valid_d;
      word_data_q   <= word_data_d;
      word_idx_q    <= word_idx_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign save_data   = save_data_q;
  assign data_clk    = data_clk_q;
  assign busy        = busy_q;
  assign word_valid  = word_valid_q;
  assign word_data   = word_data_q;
  assign word_idx    = word_idx_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule
